// File: rtl/tdm_tx.sv
`default_nettype none
// ============================================================================
// tdm_tx : I2S / left-justified / TDM serial audio transmitter, one-frame hold
// Rev 1.0
// ============================================================================
module tdm_tx #(
   parameter int    DW       = 24,
   parameter int    SLOT_W   = 32,
   parameter int    CHANNELS = 2,
   parameter int    FS_RATIO = 256,
   parameter string MODE     = "I2S"
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [CHANNELS*DW-1:0] s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic                   sclk,
   output logic                   fsync,
   output logic                   sdo,
   output logic                   underrun
);

   localparam int C_NBITS    = CHANNELS * SLOT_W;
   localparam int C_SCLK_DIV = FS_RATIO / (2 * C_NBITS);
   localparam int C_B_W      = $clog2(C_NBITS);
   localparam int C_DIV_W    = (C_SCLK_DIV > 1) ? $clog2(C_SCLK_DIV) : 1;
   localparam bit C_IS_I2S   = (MODE == "I2S");
   localparam bit C_IS_LJ    = (MODE == "LJ");
   localparam bit C_IS_TDM   = (MODE == "TDM");
   localparam bit C_CFG_OK   = (C_IS_I2S || C_IS_LJ || C_IS_TDM) &&
                               (DW >= 8) && (DW <= 32) && (SLOT_W >= DW) &&
                               (C_IS_TDM ? (CHANNELS >= 2 && CHANNELS <= 16) : (CHANNELS == 2)) &&
                               (C_SCLK_DIV >= 1) && (FS_RATIO == C_SCLK_DIV * 2 * C_NBITS);

   generate
      if (!C_CFG_OK) begin : g_bad_cfg
         $error("tdm_tx: illegal DW/SLOT_W/CHANNELS/FS_RATIO/MODE combination");
      end
   endgenerate

   logic                   r_en_d;
   logic [C_DIV_W-1:0]     r_div;
   logic [C_B_W-1:0]       r_b;
   logic [C_NBITS-1:0]     r_shift;
   logic [CHANNELS*DW-1:0] r_hold;
   logic                   r_hold_full;
   logic                   r_dly;

   logic                   w_start;
   logic                   w_term;
   logic                   w_fall;
   logic [C_B_W-1:0]       w_b_next;
   logic                   w_load;
   logic                   w_bypass;
   logic [CHANNELS*DW-1:0] w_src;
   logic [C_NBITS-1:0]     w_pad;
   logic [C_NBITS-1:0]     w_shift_next;
   logic                   w_fsync_next;

   assign w_start  = en & ~r_en_d;
   assign w_term   = (r_div == C_DIV_W'(C_SCLK_DIV - 1));
   assign w_fall   = en & (w_start | (r_en_d & w_term & sclk));
   assign w_b_next = (w_start || r_b == C_B_W'(C_NBITS - 1)) ? '0 : r_b + C_B_W'(1);
   assign w_load   = w_fall & (w_b_next == '0);
   assign w_bypass = w_load & ~r_hold_full & s_valid;
   assign w_src    = r_hold_full ? r_hold : (s_valid ? s_data : '0);

   // Whole frame laid out MSB-first with each sample left-aligned in its zero-padded slot
   always_comb begin
      w_pad = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_pad[C_NBITS-1-c*SLOT_W -: DW] = w_src[c*DW +: DW];
      end
   end

   assign w_shift_next = w_load ? w_pad : {r_shift[C_NBITS-2:0], 1'b0};

   always_comb begin
      w_fsync_next = 1'b0;
      if (C_IS_I2S)     w_fsync_next = (w_b_next >= C_B_W'(SLOT_W));
      else if (C_IS_LJ) w_fsync_next = (w_b_next <  C_B_W'(SLOT_W));
      else              w_fsync_next = (w_b_next == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_d      <= 1'b0;
         r_div       <= '0;
         r_b         <= '0;
         r_shift     <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_dly       <= 1'b0;
         s_ready     <= 1'b1;
         sclk        <= 1'b0;
         fsync       <= 1'b0;
         sdo         <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         underrun <= 1'b0;

         if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
            s_ready     <= 1'b1;
         end else if (s_valid && s_ready && !w_bypass) begin
            r_hold      <= s_data;
            r_hold_full <= 1'b1;
            s_ready     <= 1'b0;
         end

         if (!en) begin
            r_en_d <= 1'b0;
            r_div  <= '0;
            r_b    <= '0;
            r_dly  <= 1'b0;
            sclk   <= 1'b0;
            fsync  <= 1'b0;
            sdo    <= 1'b0;
         end else begin
            r_en_d <= 1'b1;
            r_div  <= (w_start || w_term) ? '0 : r_div + C_DIV_W'(1);
            if (!w_start && w_term) sclk <= ~sclk;
            if (w_fall) begin
               r_b     <= w_b_next;
               r_shift <= w_shift_next;
               // I2S runs one bit behind the slot, so the wire carries the previous bit
               r_dly   <= w_shift_next[C_NBITS-1];
               sdo     <= C_IS_I2S ? r_dly : w_shift_next[C_NBITS-1];
               fsync   <= w_fsync_next;
               if (w_load && !r_hold_full && !s_valid) underrun <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
